// File: rtl/range_finder_mc.sv
// Multi-channel range finder: tracks per-channel min/max/range/count over a
// go/finish framed burst and registers the results on the closing edge.
module range_finder_mc #(
    parameter int WIDTH     = 16,
    parameter int CHANNELS  = 4,
    parameter int CNT_WIDTH = 16,
    parameter int SIGNED    = 0,
    parameter int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          go,
    input  logic                          finish,
    input  logic                          data_valid,
    input  logic [CH_W-1:0]               chan_id,
    input  logic [WIDTH-1:0]              data_in,
    output logic [CHANNELS*WIDTH-1:0]     range,
    output logic [CHANNELS*WIDTH-1:0]     max_out,
    output logic [CHANNELS*WIDTH-1:0]     min_out,
    output logic [CHANNELS*CNT_WIDTH-1:0] count,
    output logic [CHANNELS-1:0]           empty,
    output logic                          done,
    output logic                          busy,
    output logic                          debug_error,
    output logic                          bad_chan
);

    typedef enum logic [1:0] {IDLE, READ, DONE, ERROR} state_t;

    // Smallest / largest representable sample in the selected compare mode.
    localparam logic [WIDTH-1:0] MIN_VAL = (SIGNED != 0) ? {1'b1, {(WIDTH-1){1'b0}}} : '0;
    localparam logic [WIDTH-1:0] MAX_VAL = (SIGNED != 0) ? {1'b0, {(WIDTH-1){1'b1}}} : '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    state_t state, nxt_state;

    logic [CHANNELS-1:0][WIDTH-1:0]     work_max, work_min, nxt_max, nxt_min;
    logic [CHANNELS-1:0][CNT_WIDTH-1:0] work_cnt, nxt_cnt;
    logic                               bad_q, nxt_bad;
    logic                               enter_read;

    logic [CHANNELS-1:0][WIDTH-1:0]     range_q, max_q, min_q;
    logic [CHANNELS-1:0][CNT_WIDTH-1:0] count_q;
    logic [CHANNELS-1:0]                empty_q;

    function automatic logic greater(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (SIGNED != 0) return $signed(a) > $signed(b);
        else             return a > b;
    endfunction

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        nxt_state = state;
        unique case (state)
            IDLE:    if (finish) nxt_state = ERROR;
                     else if (go) nxt_state = READ;
            READ:    if (finish) nxt_state = DONE;
            DONE:    nxt_state = go ? READ : IDLE;
            ERROR:   if (go) nxt_state = READ;
            default: nxt_state = IDLE;
        endcase
    end

    assign enter_read = (nxt_state == READ) && (state != READ);

    // Working values including this cycle's sample; the result load uses these
    // so a sample arriving alongside finish is counted.
    always_comb begin
        nxt_max = work_max;
        nxt_min = work_min;
        nxt_cnt = work_cnt;
        nxt_bad = bad_q;
        if (state == READ && data_valid) begin
            if (int'(chan_id) >= CHANNELS) begin
                nxt_bad = 1'b1;
            end else begin
                for (int c = 0; c < CHANNELS; c++) begin
                    if (int'(chan_id) == c) begin
                        if (greater(data_in, work_max[c])) nxt_max[c] = data_in;
                        if (greater(work_min[c], data_in)) nxt_min[c] = data_in;
                        if (work_cnt[c] != '1) nxt_cnt[c] = work_cnt[c] + CNT_ONE;
                    end
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= nxt_state;
    end

    // NOTE: the per-channel working arrays are small, so they are reset too;
    // this keeps simulation X-free and costs only a reset fan-out.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            work_max <= '0;
            work_min <= '0;
            work_cnt <= '0;
            bad_q    <= 1'b0;
        end else if (enter_read) begin
            for (int c = 0; c < CHANNELS; c++) begin
                work_max[c] <= MIN_VAL;
                work_min[c] <= MAX_VAL;
            end
            work_cnt <= '0;
            bad_q    <= 1'b0;
        end else begin
            work_max <= nxt_max;
            work_min <= nxt_min;
            work_cnt <= nxt_cnt;
            bad_q    <= nxt_bad;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            range_q <= '0;
            max_q   <= '0;
            min_q   <= '0;
            count_q <= '0;
            empty_q <= '1;
        end else if (state == READ && finish) begin
            for (int c = 0; c < CHANNELS; c++) begin
                count_q[c] <= nxt_cnt[c];
                if (nxt_cnt[c] == '0) begin
                    range_q[c] <= '0;
                    max_q[c]   <= '0;
                    min_q[c]   <= '0;
                    empty_q[c] <= 1'b1;
                end else begin
                    // Modular difference is the exact span in both compare modes.
                    range_q[c] <= nxt_max[c] - nxt_min[c];
                    max_q[c]   <= nxt_max[c];
                    min_q[c]   <= nxt_min[c];
                    empty_q[c] <= 1'b0;
                end
            end
        end
    end

    assign range       = range_q;
    assign max_out     = max_q;
    assign min_out     = min_q;
    assign count       = count_q;
    assign empty       = empty_q;
    assign bad_chan    = bad_q;
    assign done        = (state == DONE);
    assign busy        = (state == READ);
    assign debug_error = (state == ERROR);

endmodule

// File: doc/range_finder_mc.md
# range_finder_mc

Multi-channel, parametrised range finder: tracks per-channel minimum, maximum, range and sample count over a framed burst delimited by `go`/`finish`. It takes a valid-qualified stream of samples, each tagged with a channel ID. It supports signed or unsigned comparison and registers its results. The block sits behind the sample capture front-end and feeds the results/debug readout.

## Interface
- `WIDTH`, 16: sample width in bits.
- `CHANNELS`, 4: number of independently tracked channels (≥1).
- `CNT_WIDTH`, 16: per-channel sample counter width.
- `SIGNED`, 0: 1 = two's-complement compare, 0 = unsigned compare.
- `CH_W`, derived: `CHANNELS>1 ? $clog2(CHANNELS) : 1`.

Ports:
- `clock`  in  1: single clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `go`  in  1: start a burst.
- `finish`  in  1: end the burst.
- `data_valid`  in  1: `data_in`/`chan_id` carry a sample this cycle.
- `chan_id`  in  CH_W: channel tag of the sample.
- `data_in`  in  WIDTH: sample.
- `range`  out  CHANNELS*WIDTH: per-channel max−min, channel c at `[c*WIDTH +: WIDTH]`.
- `max_out`, `min_out`  out  CHANNELS*WIDTH: per-channel extremes, same packing.
- `count`  out  CHANNELS*CNT_WIDTH: per-channel accepted samples.
- `empty`  out  CHANNELS: channel received no samples in the last burst.
- `done`  out  1: one-cycle pulse, results updated.
- `busy`  out  1: in READ.
- `debug_error`  out  1: in ERROR state.
- `bad_chan`  out  1: sticky; a sample with `chan_id ≥ CHANNELS` was seen this burst.

## Operation
- States: IDLE, READ, DONE, ERROR.
- IDLE:
  - `finish` → ERROR. `finish` has priority over `go`.
  - else `go` → READ.
- READ:
  - `finish` → DONE. `go` is ignored.
- DONE lasts one cycle:
  - `go` → READ (back-to-back burst).
  - else → IDLE. `finish` is ignored.
- ERROR:
  - `go` → READ. `finish` keeps the block in ERROR.
- Entering READ (any source):
  - working max for every channel ← minimum representable value (0 unsigned, −2^(WIDTH−1) signed).
  - working min ← maximum representable value.
  - counts ← 0, `bad_chan` ← 0.
  - Samples are not accepted in the cycle `go` is sampled.
- In READ with `data_valid=1`:
  - `chan_id < CHANNELS`: update that channel's working max/min using the `SIGNED` compare. Count increments, saturating at all-ones.
  - `chan_id ≥ CHANNELS`: sample dropped, `bad_chan` ← 1.
- A sample valid in the same cycle `finish` is sampled is included.
- On the READ→DONE edge, result registers load from the working values, including that final sample.
- Channel with count 0 at load:
  - `min_out` = `max_out` = `range` = 0, `empty` bit = 1.
- Otherwise:
  - `range` = max − min, computed modulo 2^WIDTH and read as unsigned. This is exact for both modes.
  - `empty` bit = 0.
- Result outputs hold until the next READ→DONE load. They are unaffected by `go`, ERROR or new bursts in progress.
- `debug_error` = (state==ERROR). `busy` = (state==READ). `done` = (state==DONE).

## Timing
- Reset (`reset_n`=0, asynchronous):
  - state IDLE.
  - all outputs 0, including `range`, `min_out`, `max_out`, `count`, `done`, `busy`, `debug_error` and `bad_chan`.
  - `empty` reset value is all 1s.
- Reset asserted mid-burst aborts the burst. No `done` pulse; results are cleared.
- `go` sampled at edge k: `busy`=1 from edge k. The first accepted sample is at edge k+1.
- `finish` sampled at edge k: `done`=1 and new results visible for the cycle after edge k. `done` drops at edge k+1.
- Back-to-back: `go` high during the DONE cycle gives `busy`=1 the very next cycle, with zero idle cycles.
- All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.

## Test plan
- Unsigned, CHANNELS=4, WIDTH=16:
  - Stimulus: `go`; ch0 samples 5, 200, 17; ch2 sample 9; `finish` with ch0=3 in the same cycle.
  - Response: ch0 min 3, max 200, range 197, count 4. ch2 range 0, count 1. ch1/ch3 `empty`=1, all fields 0. One-cycle `done`.
- SIGNED=1:
  - Stimulus: ch1 samples −32768, 32767.
  - Response: range 65535, min 0x8000, max 0x7FFF.
- Error path:
  - Stimulus: `finish` from IDLE; then `finish` again; then `go`+`finish` together while in ERROR.
  - Response: `debug_error`=1 for both finishes. `go` moves the block to READ, `debug_error`=0. Prior results unchanged.
- CHANNELS=3:
  - Stimulus: sample with `chan_id`=3.
  - Response: dropped, `bad_chan`=1. Counts unchanged. `bad_chan` cleared by the next `go`.
- Back-to-back:
  - Stimulus: `go` during the DONE cycle; second burst ch0=42.
  - Response: `busy`=1 the next cycle. First burst results held until the second `done`, then ch0 range 0, count 1.
- Saturation and reset:
  - Stimulus: CNT_WIDTH=4 with 20 ch0 samples; then `reset_n` pulsed low mid-burst.
  - Response: count 15. After reset, all outputs 0, `empty`=1111, state IDLE, no `done`.
